// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler that time-shares one pipelined signed multiplier between NREQ requesters,
// tagging each issue with its requester index and gating the multiplier clock enable when idle.
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 47,
  parameter int RWIDTH  = 95,
  parameter int LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic        [NREQ-1:0]          req_valid,
  output logic        [NREQ-1:0]          req_ready,
  input  logic        [NREQ*WIDTH-1:0]    req_a,
  input  logic        [NREQ*WIDTH-1:0]    req_b,
  output logic                            mul_clken,
  output logic signed [WIDTH-1:0]         mul_a,
  output logic signed [WIDTH-1:0]         mul_b,
  input  logic signed [RWIDTH-1:0]        mul_out,
  output logic                            res_valid,
  output logic        [$clog2(NREQ)-1:0]  res_id,
  output logic signed [RWIDTH-1:0]        res_data,
  output logic                            busy
);

  localparam int IDW = $clog2(NREQ);

  logic        [IDW-1:0]   last;
  logic        [NREQ-1:0]  grant;
  logic        [IDW-1:0]   grant_id;
  logic                    accept;
  logic signed [WIDTH-1:0] a_sel;
  logic signed [WIDTH-1:0] b_sel;

  logic                    slot_valid;
  logic        [IDW-1:0]   slot_id;
  logic        [LATENCY:0] tag_vld;
  logic        [IDW-1:0]   tag_id [LATENCY+1];

  // Round-robin search starting just after the last winner, wrapping at NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (int'(last) + off) % NREQ;
      if (grant == '0 && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

  // Reset is folded in so the grant lines read zero as soon as rst falls.
  assign req_ready = (enable && rst) ? grant : '0;
  assign accept    = |req_ready;
  assign a_sel     = req_a[int'(grant_id)*WIDTH +: WIDTH];
  assign b_sel     = req_b[int'(grant_id)*WIDTH +: WIDTH];

  assign mul_clken = slot_valid | (|tag_vld);
  assign busy      = mul_clken;

  // Stage: issue slot (operand registers feeding the multiplier)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last       <= IDW'(NREQ-1);
      slot_valid <= 1'b0;
      slot_id    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      slot_valid <= accept;
      if (accept) begin
        last    <= grant_id;
        slot_id <= grant_id;
        mul_a   <= a_sel;
        mul_b   <= b_sel;
      end
    end
  end

  // Stage: tag pipeline, advancing in lockstep with the multiplier's enabled edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_id[i] <= '0;
    end else if (mul_clken) begin
      tag_vld   <= {tag_vld[LATENCY-1:0], slot_valid};
      tag_id[0] <= slot_id;
      for (int i = 1; i <= LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  // Stage: result register, capturing mul_out as the oldest tag leaves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= tag_vld[LATENCY] & mul_clken;
      if (tag_vld[LATENCY] && mul_clken) begin
        res_id   <= tag_id[LATENCY];
        res_data <= mul_out;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: arbitration table, directed corner sequences and random traffic,
// all checked against a transaction-level scoreboard with a behavioural pipelined multiplier.
module tb_mul_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 47;
  localparam int R    = 95;
  localparam int L    = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   enable = 1'b0;
  logic        [NREQ-1:0] req_valid = '0;
  logic        [NREQ-1:0] req_ready;
  logic      [NREQ*W-1:0] req_a, req_b;
  logic                   mul_clken;
  logic signed [W-1:0]    mul_a, mul_b;
  logic signed [R-1:0]    mul_out, res_data;
  logic                   res_valid;
  logic        [1:0]      res_id;
  logic                   busy;

  logic signed [W-1:0]    a_in [NREQ];
  logic signed [W-1:0]    b_in [NREQ];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_res = 0;
  int model_last = NREQ-1;
  logic [NREQ-1:0] rdy_seen;
  int grant_log[$];
  logic signed [R-1:0] res_by_id [NREQ];

  typedef struct {
    int                  id;
    logic signed [R-1:0] prod;
    int                  due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic            en;
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] rdy;
  } vec_t;
  vec_t tbl[15];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = a_in[i];
      req_b[i*W +: W] = b_in[i];
    end
  end

  mul_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .RWIDTH(R), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_clken(mul_clken), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  function automatic logic signed [R-1:0] sext(input logic signed [W-1:0] v);
    logic signed [R-1:0] r;
    r = v;
    return r;
  endfunction

  // Behavioural multiplier: product appears L enabled edges after the sampling edge.
  logic signed [R-1:0] mp [L+1];
  always @(posedge clk) begin
    if (mul_clken) begin
      mp[0] <= sext(mul_a) * sext(mul_b);
      for (int i = 1; i <= L; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_out = mp[L];

  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] rv, input logic en,
                                                  input int lst);
    logic [NREQ-1:0] g;
    g = '0;
    if (en) begin
      for (int off = 1; off <= NREQ; off++) begin
        int k;
        k = (lst + off) % NREQ;
        if (g == '0 && rv[k]) g[k] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] eg;
    logic            exp_rv;
    @(negedge clk);
    eg = model_grant(req_valid, enable && rst, model_last);
    rdy_seen = req_ready;
    check("req_ready", req_ready, eg);
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        sb.push_back('{i, sext(a_in[i]) * sext(b_in[i]), cyc + L + 2});
        model_last = i;
        grant_log.push_back(i);
      end
    end
    #1;
    exp_rv = (sb.size() != 0) && (sb[0].due == cyc);
    check("res_valid", res_valid, exp_rv);
    if (res_valid) n_res++;
    if (exp_rv) begin
      if (res_valid) begin
        check("res_id", res_id, sb[0].id);
        check("res_data", res_data, sb[0].prod);
        res_by_id[sb[0].id] = res_data;
      end
      void'(sb.pop_front());
    end
    check("busy", busy, sb.size() != 0);
    check("mul_clken", mul_clken, sb.size() != 0);
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = W'({$urandom(), $urandom()});
      b_in[i] = W'({$urandom(), $urandom()});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    req_valid = '0;
    sb.delete();
    model_last = NREQ-1;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic signed [W-1:0] amin, amax;
    logic signed [R-1:0] e1, e2, lat_data;
    int acc, lat, lat_id;
    logic [NREQ-1:0] rv_hold;

    amin = {1'b1, {(W-1){1'b0}}};
    amax = {1'b0, {(W-1){1'b1}}};
    for (int i = 0; i < NREQ; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end

    tbl[0]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[3]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[6]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[7]  = '{1'b1, 4'b1010, 4'b1000};
    tbl[8]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[10] = '{1'b1, 4'b0100, 4'b0100};
    tbl[11] = '{1'b1, 4'b0100, 4'b0100};
    tbl[12] = '{1'b1, 4'b0001, 4'b0001};
    tbl[13] = '{1'b1, 4'b1001, 4'b1000};
    tbl[14] = '{1'b1, 4'b1001, 4'b0001};

    // Reset state
    #2;
    check("rst_ready", req_ready, 4'b0);
    check("rst_clken", mul_clken, 1'b0);
    check("rst_mul_a", mul_a, 47'd0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    do_reset();

    // Arbitration table from a fresh reset
    for (int i = 0; i < 15; i++) begin
      enable = tbl[i].en;
      req_valid = tbl[i].rv;
      randomize_ops();
      step();
      check($sformatf("tbl_rdy[%0d]", i), rdy_seen, tbl[i].rdy);
    end
    drain(10);

    // Single request from requester 2: latency, tag and sign extension
    do_reset();
    enable = 1'b1;
    a_in[2] = 47'sd3;
    b_in[2] = -47'sd5;
    req_valid = 4'b0100;
    step();
    acc = cyc;
    req_valid = '0;
    lat = -1;
    lat_id = -1;
    lat_data = '0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      step();
      if (res_valid) begin
        lat = cyc - acc;
        lat_id = res_id;
        lat_data = res_data;
      end
    end
    check("single_latency", lat, L + 2);
    check("single_id", lat_id, 2);
    e1 = -95'sd15;
    check("single_data", lat_data, e1);
    step();
    check("single_busy_after", busy, 1'b0);

    // All requesters held valid for 8 cycles: rotation and back-to-back results
    do_reset();
    enable = 1'b1;
    req_valid = 4'b1111;
    grant_log.delete();
    n_res = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_in[i] = W'(1000 * i + k + 1);
        b_in[i] = -W'(7 * i + 3 * k + 2);
      end
      step();
    end
    drain(10);
    for (int k = 0; k < 8; k++) check($sformatf("rotate[%0d]", k), grant_log[k], k % 4);
    check("rotate_results", n_res, 8);

    // Operand extremes; pointer sits at 3 so requester 0 then 1 win
    a_in[0] = amin; b_in[0] = amin;
    a_in[1] = amin; b_in[1] = amax;
    req_valid = 4'b0011;
    step();
    step();
    drain(10);
    e1 = '0;
    e1[92] = 1'b1;
    e2 = -e1 + (sext(47'sd1) <<< 46);
    check("ext_minmin", res_by_id[0], e1);
    check("ext_minmax", res_by_id[1], e2);

    // Sparse issue: one accept every 3 cycles, clken must bridge the gaps
    n_res = 0;
    for (int k = 0; k < 4; k++) begin
      randomize_ops();
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
      step();
    end
    drain(10);
    check("sparse_results", n_res, 4);
    check("sparse_clken_idle", mul_clken, 1'b0);

    // Enable dropped with 3 in flight
    n_res = 0;
    randomize_ops();
    req_valid = 4'b1111;
    step(); step(); step();
    enable = 1'b0;
    #1;
    check("en_drop_ready", req_ready, 4'b0);
    for (int i = 0; i < 10; i++) step();
    check("en_drop_results", n_res, 3);
    check("en_drop_busy", busy, 1'b0);

    // Asynchronous reset with 2 operations in flight
    enable = 1'b1;
    randomize_ops();
    req_valid = 4'b0011;
    step(); step();
    #3;
    rst = 1'b0;
    #1;
    check("arst_ready", req_ready, 4'b0);
    check("arst_clken", mul_clken, 1'b0);
    check("arst_mul_a", mul_a, 47'd0);
    check("arst_mul_b", mul_b, 47'd0);
    check("arst_res_valid", res_valid, 1'b0);
    check("arst_res_id", res_id, 2'd0);
    check("arst_res_data", res_data, 95'd0);
    check("arst_busy", busy, 1'b0);
    sb.delete();
    model_last = NREQ-1;
    step(); step();
    rst = 1'b1;
    n_res = 0;
    drain(10);
    check("arst_no_results", n_res, 0);
    grant_log.delete();
    req_valid = 4'b1111;
    step();
    check("arst_first_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    drain(10);

    // Random traffic against the scoreboard
    for (int k = 0; k < 300; k++) begin
      enable = ($urandom_range(0, 9) != 0);
      rv_hold = NREQ'($urandom());
      req_valid = rv_hold;
      randomize_ops();
      step();
    end
    enable = 1'b1;
    drain(12);
    check("final_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
